// File: rtl/div_clk_tick_counter.sv
// div_clk_tick_counter
//   Samples the divider's output clock and mode flag as plain data in the fast
//   clock domain and turns each divided-clock rising edge into a one-cycle
//   tick. It also counts ticks, restarts cleanly on a mode change, and
//   provides an optional stall watchdog.
//   Optional feature: define TICK_WATCHDOG_EN to build the stall watchdog.
//   When the macro is undefined, stall is tied to 0.
module div_clk_tick_counter #(
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int CNT_WIDTH   = 16,
  parameter int WDOG_LIMIT  = 64
) (
  input  logic                 internal_clk_fgpa,
  input  logic                 rst_n,
  input  logic                 div_clk_in,
  input  logic                 slow_clk_in,
  input  logic                 cnt_en,
  input  logic                 cnt_clr,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 count_wrap,
  output logic                 mode_chg,
  output logic [1:0]           state,
  output logic                 stall
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // mode_chg stays blocked until the slow_clk chain has flushed its reset contents
  localparam int WARM_MAX = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0] div_sync;
  logic [SYNC_STAGES-1:0] slow_sync;
  logic                   div_d;
  logic                   slow_d;
  logic [2:0]             warm_cnt;
  logic                   warm_ok;
  logic                   tick_cond;
  logic                   mode_cond;

  logic [1:0]             state_next;
  logic [CNT_WIDTH-1:0]   count_next;
  logic                   wrap_next;

  // Synchroniser chains plus one-cycle-delayed copies for edge detection
  always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
    if (!rst_n) begin
      div_sync  <= '0;
      slow_sync <= '0;
      div_d     <= 1'b0;
      slow_d    <= 1'b0;
    end else begin
      div_sync  <= {div_sync[SYNC_STAGES-2:0], div_clk_in};
      slow_sync <= {slow_sync[SYNC_STAGES-2:0], slow_clk_in};
      div_d     <= div_sync[SYNC_STAGES-1];
      slow_d    <= slow_sync[SYNC_STAGES-1];
    end
  end

  // Post-reset warm-up counter that masks mode_chg until the chain is flushed
  always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= 3'd0;
    end else if (!warm_ok) begin
      warm_cnt <= warm_cnt + 3'd1;
    end
  end

  assign warm_ok   = (warm_cnt == 3'(WARM_MAX));
  assign tick_cond = div_sync[SYNC_STAGES-1] & ~div_d;
  assign mode_cond = (slow_sync[SYNC_STAGES-1] ^ slow_d) & warm_ok;

  // Next-state and next-count logic with clear taking precedence over everything
  always_comb begin
    state_next = state;
    count_next = count;
    wrap_next  = 1'b0;
    if (!cnt_en) begin
      state_next = ST_IDLE;
    end else if (mode_cond) begin
      state_next = ST_ARMED;
      count_next = '0;
    end else if (state == ST_IDLE) begin
      state_next = ST_ARMED;
    end else if (state == ST_ARMED) begin
      // The first edge after arming closes a partial period; it is not counted
      if (tick_cond) begin
        state_next = ST_RUN;
      end
    end else if (state == ST_RUN) begin
      if (tick_cond) begin
        count_next = count + 1'b1;
        wrap_next  = &count;
      end
    end else begin
      state_next = ST_IDLE;
    end
    if (cnt_clr) begin
      count_next = '0;
      wrap_next  = 1'b0;
    end
  end

  // Registered outputs; all of them change on the same edge
  always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
    if (!rst_n) begin
      tick       <= 1'b0;
      mode_chg   <= 1'b0;
      count_wrap <= 1'b0;
      count      <= '0;
      state      <= ST_IDLE;
    end else begin
      tick       <= tick_cond;
      mode_chg   <= mode_cond;
      count_wrap <= wrap_next;
      count      <= count_next;
      state      <= state_next;
    end
  end

`ifdef TICK_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Quiet-cycle counter: runs while armed or running and saturates at the limit
  always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (state == ST_IDLE || tick_cond || cnt_clr) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != WDOG_W'(WDOG_LIMIT)) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // Sticky stall flag; a tick, a clear or a drop to IDLE releases it
  always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
    if (!rst_n) begin
      stall <= 1'b0;
    end else if (tick_cond || cnt_clr || state_next == ST_IDLE) begin
      stall <= 1'b0;
    end else if (wdog_cnt == WDOG_W'(WDOG_LIMIT)) begin
      stall <= 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_div_clk_tick_counter.sv
// Testbench for div_clk_tick_counter (CNT_WIDTH=4 so that wrap is reachable quickly).
// The reference model keeps a history of sampled inputs and applies the
// latency and priority rules directly.
module tb_div_clk_tick_counter;

  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int MODV = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          div_clk_in;
  logic          slow_clk_in;
  logic          cnt_en;
  logic          cnt_clr;
  logic          tick;
  logic [CW-1:0] count;
  logic          count_wrap;
  logic          mode_chg;
  logic [1:0]    state;
  logic          stall;

  div_clk_tick_counter #(.SYNC_STAGES(SYNC), .CNT_WIDTH(CW), .WDOG_LIMIT(64)) dut (
    .internal_clk_fgpa(clk),
    .rst_n(rst_n),
    .div_clk_in(div_clk_in),
    .slow_clk_in(slow_clk_in),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .tick(tick),
    .count(count),
    .count_wrap(count_wrap),
    .mode_chg(mode_chg),
    .state(state),
    .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model
  bit hd[$];
  bit hs[$];
  int m_st  = 0;
  int m_cnt = 0;
  bit m_tick, m_mode, m_wrap;
  int tick_seen, wrap_seen, mode_seen;
  bit cur_en   = 1'b0;
  bit cur_slow = 1'b0;
  bit clr_on_wrap = 1'b0;
  bit clr_on_tick = 1'b0;

  function automatic bit hd_at(int i);
    return (i < 0) ? 1'b0 : hd[i];
  endfunction

  function automatic bit hs_at(int i);
    return (i < 0) ? 1'b0 : hs[i];
  endfunction

  // A rising edge seen at sample k reaches the detector SYNC edges later
  function automatic bit tick_at(int k);
    return hd_at(k - SYNC) & ~hd_at(k - SYNC - 1);
  endfunction

  function automatic bit mode_at(int k);
    return (k >= SYNC + 1) && (hs_at(k - SYNC) ^ hs_at(k - SYNC - 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, compare all outputs
  task automatic step(input bit d, input bit clr_in);
    int  k;
    bit  clr;
    k   = hd.size();
    clr = clr_in;
    if (clr_on_wrap && m_st == 2 && m_cnt == MODV - 1 && tick_at(k) && !mode_at(k)) begin
      clr = 1'b1;
      clr_on_wrap = 1'b0;
    end
    if (clr_on_tick && tick_at(k)) begin
      clr = 1'b1;
      clr_on_tick = 1'b0;
    end
    div_clk_in  = d;
    slow_clk_in = cur_slow;
    cnt_en      = cur_en;
    cnt_clr     = clr;
    @(posedge clk);
    hd.push_back(d);
    hs.push_back(cur_slow);
    m_tick = tick_at(k);
    m_mode = mode_at(k);
    m_wrap = 1'b0;
    if (!cur_en) m_st = 0;
    else if (m_mode) begin m_st = 1; m_cnt = 0; end
    else if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin if (m_tick) m_st = 2; end
    else if (m_tick) begin
      m_wrap = (m_cnt == MODV - 1);
      m_cnt  = (m_cnt + 1) % MODV;
    end
    if (clr) begin m_cnt = 0; m_wrap = 1'b0; end
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("mode_chg", 32'(mode_chg), 32'(m_mode));
    check("count_wrap", 32'(count_wrap), 32'(m_wrap));
    check("count", 32'(count), 32'(m_cnt));
    check("state", 32'(state), 32'(m_st));
`ifndef TICK_WATCHDOG_EN
    check("stall", 32'(stall), 32'd0);
`endif
    if (tick === 1'b1) tick_seen++;
    if (count_wrap === 1'b1) wrap_seen++;
    if (mode_chg === 1'b1) mode_seen++;
  endtask

  task automatic hold(input bit d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0);
  endtask

  // One divided-clock period: low then high, rising edge in the middle
  task automatic period(input int lo, input int hi);
    hold(1'b0, lo);
    hold(1'b1, hi);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) period(2, 2);
    hold(1'b0, 4);
  endtask

  initial begin
    // 1: reset with div_clk_in high
    rst_n = 1'b0; div_clk_in = 1'b1; slow_clk_in = 1'b1; cnt_en = 1'b0; cnt_clr = 1'b0;
    cur_slow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_wrap", 32'(count_wrap), 32'd0);
      check("rst_mode", 32'(mode_chg), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
    end
    rst_n = 1'b1;
    tick_seen = 0; mode_seen = 0;
    hold(1'b1, 8);
    $display("release: ticks=%0d mode=%0d state=%0d count=%0d", tick_seen, mode_seen, state, count);
    check("release_ticks", 32'(tick_seen), 32'd1);
    check("release_mode", 32'(mode_seen), 32'd0);
    check("release_state", 32'(state), 32'd0);

    // 2: counting with period 32
    cur_en = 1'b1;
    tick_seen = 0;
    for (int p = 0; p < 6; p++) period(16, 16);
    hold(1'b0, 8);
    $display("count: ticks=%0d count=%0d state=%0d", tick_seen, count, state);
    check("cnt_ticks", 32'(tick_seen), 32'd6);
    check("cnt_value", 32'(count), 32'd5);
    check("cnt_state", 32'(state), 32'd2);

    // 3: wrap, then clear landing on the wrap edge
    wrap_seen = 0;
    ticks(16);
    $display("wrap: wraps=%0d count=%0d", wrap_seen, count);
    check("wrap_seen", 32'(wrap_seen), 32'd1);
    check("wrap_count", 32'(count), 32'd5);
    wrap_seen = 0;
    clr_on_wrap = 1'b1;
    ticks(16);
    $display("wrap+clr: wraps=%0d count=%0d", wrap_seen, count);
    check("wrapclr_seen", 32'(wrap_seen), 32'd0);
    check("wrapclr_count", 32'(count), 32'd5);

    // 4: mode change at count 7
    step(1'b0, 1'b1);
    ticks(7);
    check("mode_pre", 32'(count), 32'd7);
    mode_seen = 0;
    cur_slow = 1'b0;
    hold(1'b0, 6);
    $display("mode: pulses=%0d count=%0d state=%0d", mode_seen, count, state);
    check("mode_pulse", 32'(mode_seen), 32'd1);
    check("mode_count", 32'(count), 32'd0);
    check("mode_state", 32'(state), 32'd1);
    ticks(1);
    check("mode_tick1", 32'(count), 32'd0);
    check("mode_run", 32'(state), 32'd2);
    ticks(1);
    check("mode_tick2", 32'(count), 32'd1);

    // 5: clear beats increment, then disable
    step(1'b0, 1'b1);
    ticks(3);
    check("prio_pre", 32'(count), 32'd3);
    clr_on_tick = 1'b1;
    ticks(1);
    check("prio_clr", 32'(count), 32'd0);
    ticks(2);
    cur_en = 1'b0;
    hold(1'b0, 2);
    tick_seen = 0;
    ticks(3);
    $display("disable: ticks=%0d count=%0d state=%0d", tick_seen, count, state);
    check("idle_ticks", 32'(tick_seen), 32'd3);
    check("idle_count", 32'(count), 32'd2);
    check("idle_state", 32'(state), 32'd0);

    // random phase
    begin
      bit d = 1'b0;
      int run = 0;
      for (int i = 0; i < 1500; i++) begin
        if (run == 0) begin d = ~d; run = $urandom_range(1, 6); end
        run--;
        cur_en = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 39) == 0) cur_slow = ~cur_slow;
        step(d, $urandom_range(0, 31) == 0);
      end
      $display("random: model count=%0d state=%0d", m_cnt, m_st);
    end

    // 6: watchdog
    cur_en = 1'b1;
    ticks(3);
`ifdef TICK_WATCHDOG_EN
    hold(1'b0, 70);
    check("wdog_stall", 32'(stall), 32'd1);
    ticks(1);
    check("wdog_clear", 32'(stall), 32'd0);
`else
    hold(1'b0, 70);
    check("stall_off", 32'(stall), 32'd0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
